sdram_cmd_engine: RTL and testbench

SDRAM_CMD_ENGINE -- requirements
Module: sdram_cmd_engine

---
 rtl/sdram_cmd_engine.sv | 266 ++++++++++++++++++++++++++
 tb/tb_sdram_cmd_engine.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/sdram_cmd_engine.sv
// rtl/sdram_cmd_engine.sv - SDRAM command engine: init, auto-refresh, 4-beat burst read/write
//
// Purpose: drives an SDR SDRAM through its power-up sequence, then arbitrates
// between periodic auto-refresh, burst writes and burst reads (refresh > write
// > read). Each burst is ACT, then WR/RD with auto-precharge (A10=1).
//
// Ports:
//   S_CLK, RST_N            clock (rising edge), synchronous active-low reset
//   write_en/read_en/addr   request levels held until write_ack/read_ack
//   write_ack/read_ack      one-cycle completion pulses
//   wr_data/wr_data_req     write beat data; each beat's word is captured on
//                           the edge that opens that beat
//   rd_data/rd_data_valid   read beat data, valid for the 4 beat cycles
//   sdram_*                 registered SDRAM pins; dq_out/dq_oe drive the pad
//   sdram_dq_in             read data from the pad (registered once)
module sdram_cmd_engine #(
  parameter int INIT_WAIT  = 20000,
  parameter int REF_PERIOD = 780,
  parameter int T_RP       = 2,
  parameter int T_RCD      = 2,
  parameter int T_RFC      = 7,
  parameter int T_MRD      = 2,
  parameter int T_WR       = 2,
  parameter int CL         = 2
) (
  input  logic        S_CLK,
  input  logic        RST_N,
  input  logic        write_en,
  input  logic        read_en,
  input  logic [19:0] addr,
  output logic        write_ack,
  output logic        read_ack,
  input  logic [15:0] wr_data,
  output logic        wr_data_req,
  output logic [15:0] rd_data,
  output logic        rd_data_valid,
  output logic        sdram_cke,
  output logic        sdram_cs_n,
  output logic        sdram_ras_n,
  output logic        sdram_cas_n,
  output logic        sdram_we_n,
  output logic [1:0]  sdram_ba,
  output logic [11:0] sdram_addr,
  output logic [1:0]  sdram_dqm,
  output logic [15:0] sdram_dq_out,
  output logic        sdram_dq_oe,
  input  logic [15:0] sdram_dq_in
);

  typedef enum logic [2:0] {INIT, IDLE, REFRESH, ACTIVE, WRITE, READ, RECOVER} state_t;
  typedef enum logic [2:0] {IS_WAIT, IS_PRE, IS_REF1, IS_REF2, IS_MRS} init_step_t;

  // {cs_n, ras_n, cas_n, we_n}; DESL keeps the chip deselected while in reset
  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_ACT  = 4'b0011;
  localparam logic [3:0] CMD_RD   = 4'b0101;
  localparam logic [3:0] CMD_WR   = 4'b0100;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_REF  = 4'b0001;
  localparam logic [3:0] CMD_MRS  = 4'b0000;
  localparam logic [3:0] CMD_DESL = 4'b1111;

  state_t     r_state, w_state_nxt;
  init_step_t r_step, w_step_nxt;
  logic [15:0] r_cnt, w_cnt_nxt;
  logic        r_is_write, w_is_write_nxt;
  logic        r_init_done, w_init_done_set;
  logic [15:0] r_ref_cnt;
  logic        r_ref_pend, w_ref_clr;
  logic [7:0]  r_col, w_col_nxt;
  logic [3:0]  r_cmd, w_cmd_nxt;
  logic [1:0]  r_ba, w_ba_nxt;
  logic [11:0] r_addr, w_addr_nxt;
  logic        r_cke, r_dq_oe, w_dq_oe_nxt;
  logic [15:0] r_dq_out, r_rd_data;
  logic        r_wr_req, w_wr_req_nxt;
  logic        r_rd_valid, w_rd_valid_nxt;
  logic        r_wack, w_wack_nxt, r_rack, w_rack_nxt;
  logic [1:0]  r_dqm;

  // Pin values are computed for the cycle being entered, so a command appears
  // in the first cycle of its state and each state's counter starts at 0 there.
  always_comb begin
    w_state_nxt     = r_state;
    w_step_nxt      = r_step;
    w_cnt_nxt       = r_cnt + 16'd1;
    w_is_write_nxt  = r_is_write;
    w_init_done_set = 1'b0;
    w_ref_clr       = 1'b0;
    w_col_nxt       = r_col;
    w_cmd_nxt       = CMD_NOP;
    w_ba_nxt        = r_ba;
    w_addr_nxt      = r_addr;
    w_dq_oe_nxt     = 1'b0;
    w_wr_req_nxt    = 1'b0;
    w_rd_valid_nxt  = 1'b0;
    w_wack_nxt      = 1'b0;
    w_rack_nxt      = 1'b0;
    case (r_state)
      INIT: begin
        case (r_step)
          IS_WAIT: if (r_cnt == 16'(INIT_WAIT)) begin
            w_cmd_nxt  = CMD_PRE;
            w_addr_nxt = 12'h400;
            w_ba_nxt   = 2'b00;
            w_step_nxt = IS_PRE;
            w_cnt_nxt  = '0;
          end
          IS_PRE: if (r_cnt == 16'(T_RP - 1)) begin
            w_cmd_nxt  = CMD_REF;
            w_step_nxt = IS_REF1;
            w_cnt_nxt  = '0;
          end
          IS_REF1: if (r_cnt == 16'(T_RFC - 1)) begin
            w_cmd_nxt  = CMD_REF;
            w_step_nxt = IS_REF2;
            w_cnt_nxt  = '0;
          end
          IS_REF2: if (r_cnt == 16'(T_RFC - 1)) begin
            w_cmd_nxt  = CMD_MRS;
            w_addr_nxt = 12'h022;
            w_ba_nxt   = 2'b00;
            w_step_nxt = IS_MRS;
            w_cnt_nxt  = '0;
          end
          IS_MRS: if (r_cnt == 16'(T_MRD - 1)) begin
            w_state_nxt     = IDLE;
            w_init_done_set = 1'b1;
            w_cnt_nxt       = '0;
          end
          default: begin
            w_step_nxt = IS_WAIT;
            w_cnt_nxt  = '0;
          end
        endcase
      end
      IDLE: begin
        w_cnt_nxt = '0;
        if (r_ref_pend) begin
          w_state_nxt = REFRESH;
          w_cmd_nxt   = CMD_REF;
          w_ref_clr   = 1'b1;
        end else if (write_en || read_en) begin
          // write wins a tie; addr is only sampled here
          w_state_nxt    = ACTIVE;
          w_cmd_nxt      = CMD_ACT;
          w_is_write_nxt = write_en;
          w_ba_nxt       = addr[19:18];
          w_addr_nxt     = {2'b00, addr[17:8]};
          w_col_nxt      = addr[7:0];
        end
      end
      REFRESH: if (r_cnt == 16'(T_RFC - 1)) begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
      ACTIVE: if (r_cnt == 16'(T_RCD - 1)) begin
        w_cnt_nxt  = '0;
        w_addr_nxt = {4'b0100, r_col};
        if (r_is_write) begin
          w_state_nxt  = WRITE;
          w_cmd_nxt    = CMD_WR;
          w_dq_oe_nxt  = 1'b1;
          w_wr_req_nxt = 1'b1;
        end else begin
          w_state_nxt = READ;
          w_cmd_nxt   = CMD_RD;
        end
      end
      WRITE: begin
        if (r_cnt == 16'd3) begin
          w_state_nxt = RECOVER;
          w_cnt_nxt   = '0;
        end else begin
          w_dq_oe_nxt  = 1'b1;
          w_wr_req_nxt = 1'b1;
        end
      end
      RECOVER: if (r_cnt == 16'(T_WR + T_RP - 1)) begin
        w_state_nxt = IDLE;
        w_wack_nxt  = 1'b1;
        w_cnt_nxt   = '0;
      end
      READ: begin
        // RD cycle has count 0; beats land in counts CL+1..CL+4
        w_rd_valid_nxt = (r_cnt >= 16'(CL)) && (r_cnt <= 16'(CL + 3));
        if (r_cnt == 16'(CL + 4)) begin
          w_state_nxt = IDLE;
          w_rack_nxt  = 1'b1;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = INIT;
        w_step_nxt  = IS_WAIT;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge S_CLK) begin
    if (!RST_N) begin
      r_state     <= INIT;
      r_step      <= IS_WAIT;
      r_cnt       <= '0;
      r_is_write  <= 1'b0;
      r_init_done <= 1'b0;
      r_ref_cnt   <= '0;
      r_ref_pend  <= 1'b0;
      r_col       <= '0;
      r_cmd       <= CMD_DESL;
      r_ba        <= '0;
      r_addr      <= '0;
      r_cke       <= 1'b0;
      r_dq_oe     <= 1'b0;
      r_dq_out    <= '0;
      r_wr_req    <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_rd_data   <= '0;
      r_wack      <= 1'b0;
      r_rack      <= 1'b0;
      r_dqm       <= 2'b00;
    end else begin
      r_state     <= w_state_nxt;
      r_step      <= w_step_nxt;
      r_cnt       <= w_cnt_nxt;
      r_is_write  <= w_is_write_nxt;
      r_init_done <= r_init_done | w_init_done_set;
      r_col       <= w_col_nxt;
      r_cmd       <= w_cmd_nxt;
      r_ba        <= w_ba_nxt;
      r_addr      <= w_addr_nxt;
      r_cke       <= 1'b1;
      r_dq_oe     <= w_dq_oe_nxt;
      r_dq_out    <= w_dq_oe_nxt ? wr_data : 16'h0000;
      r_wr_req    <= w_wr_req_nxt;
      r_rd_valid  <= w_rd_valid_nxt;
      r_rd_data   <= sdram_dq_in;
      r_wack      <= w_wack_nxt;
      r_rack      <= w_rack_nxt;
      r_dqm       <= 2'b00;
      // a new refresh request wins over the clear from a REF in the same cycle
      if (r_init_done && r_ref_cnt == 16'(REF_PERIOD - 1)) begin
        r_ref_cnt  <= '0;
        r_ref_pend <= 1'b1;
      end else begin
        if (r_init_done) r_ref_cnt <= r_ref_cnt + 16'd1;
        if (w_ref_clr) r_ref_pend <= 1'b0;
      end
    end
  end

  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = r_cmd;
  assign sdram_cke     = r_cke;
  assign sdram_ba      = r_ba;
  assign sdram_addr    = r_addr;
  assign sdram_dqm     = r_dqm;
  assign sdram_dq_out  = r_dq_out;
  assign sdram_dq_oe   = r_dq_oe;
  assign wr_data_req   = r_wr_req;
  assign rd_data       = r_rd_data;
  assign rd_data_valid = r_rd_valid;
  assign write_ack     = r_wack;
  assign read_ack      = r_rack;

endmodule

// File: tb/tb_sdram_cmd_engine.sv
// tb/tb_sdram_cmd_engine.sv - directed bench for sdram_cmd_engine
module tb_sdram_cmd_engine;

  localparam int CL = 2;
  localparam logic [3:0] NOP = 4'b0111, ACT = 4'b0011, RD = 4'b0101, WR = 4'b0100;
  localparam logic [3:0] PRE = 4'b0010, REF = 4'b0001, MRS = 4'b0000, DESL = 4'b1111;

  logic        S_CLK = 1'b0;
  logic        RST_N;
  logic        write_en, read_en;
  logic [19:0] addr;
  logic        write_ack, read_ack;
  logic [15:0] wr_data;
  logic        wr_data_req;
  logic [15:0] rd_data;
  logic        rd_data_valid;
  logic        sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
  logic [1:0]  sdram_ba;
  logic [11:0] sdram_addr;
  logic [1:0]  sdram_dqm;
  logic [15:0] sdram_dq_out;
  logic        sdram_dq_oe;
  logic [15:0] sdram_dq_in;

  sdram_cmd_engine #(.INIT_WAIT(20), .REF_PERIOD(25)) dut (
    .S_CLK(S_CLK), .RST_N(RST_N), .write_en(write_en), .read_en(read_en),
    .addr(addr), .write_ack(write_ack), .read_ack(read_ack), .wr_data(wr_data),
    .wr_data_req(wr_data_req), .rd_data(rd_data), .rd_data_valid(rd_data_valid),
    .sdram_cke(sdram_cke), .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n),
    .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n), .sdram_ba(sdram_ba),
    .sdram_addr(sdram_addr), .sdram_dqm(sdram_dqm), .sdram_dq_out(sdram_dq_out),
    .sdram_dq_oe(sdram_dq_oe), .sdram_dq_in(sdram_dq_in)
  );

  always #5 S_CLK = ~S_CLK;

  logic [3:0]  lg_cmd  [0:159];
  logic [1:0]  lg_ba   [0:159];
  logic [11:0] lg_addr [0:159];
  logic [1:0]  lg_dqm  [0:159];
  logic [15:0] lg_dqo  [0:159];
  logic [15:0] lg_rdd  [0:159];
  logic        lg_cke  [0:159];
  logic        lg_oe   [0:159];
  logic        lg_wreq [0:159];
  logic        lg_rval [0:159];
  logic        lg_wack [0:159];
  logic        lg_rack [0:159];
  logic [15:0] mem [0:3];
  int cyc, checks, errors, widx, mwi, rt;

  task automatic record(input int c);
    lg_cmd[c]  = {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n};
    lg_ba[c]   = sdram_ba;
    lg_addr[c] = sdram_addr;
    lg_dqm[c]  = sdram_dqm;
    lg_dqo[c]  = sdram_dq_out;
    lg_rdd[c]  = rd_data;
    lg_cke[c]  = sdram_cke;
    lg_oe[c]   = sdram_dq_oe;
    lg_wreq[c] = wr_data_req;
    lg_rval[c] = rd_data_valid;
    lg_wack[c] = write_ack;
    lg_rack[c] = read_ack;
  endtask

  // One clock: sample at the falling edge, then update host and DQ models.
  task automatic step();
    @(posedge S_CLK);
    cyc++;
    @(negedge S_CLK);
    record(cyc);
    if (wr_data_req && widx < 15) widx++;
    wr_data = 16'(widx + 1);
    if (sdram_dq_oe) begin
      mem[mwi] = sdram_dq_out;
      mwi = (mwi + 1) % 4;
    end
    if ({sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} == RD) rt = 0;
    else if (rt >= 0) rt++;
    sdram_dq_in = (rt >= CL && rt < CL + 4) ? mem[rt - CL] : 16'h0000;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc %0d observed %0h expected %0h", tag, c, obs, exp);
    end
  endtask

  function automatic logic [3:0] init_cmd(input int k);
    case (k)
      21:      return PRE;
      23, 30:  return REF;
      37:      return MRS;
      default: return NOP;
    endcase
  endfunction

  initial begin
    cyc = 0; checks = 0; errors = 0; widx = 0; mwi = 0; rt = -1;
    RST_N = 1'b0; write_en = 1'b0; read_en = 1'b0; addr = '0;
    wr_data = 16'd1; sdram_dq_in = '0;
    for (int i = 0; i < 4; i++) mem[i] = '0;

    repeat (3) @(posedge S_CLK);
    @(negedge S_CLK);
    record(0);
    RST_N = 1'b1;

    run_to(37);
    write_en = 1'b1; addr = 20'hC0105;      // held through INIT cycles 38..39
    run_to(41);
    addr = 20'h12345;                       // must not disturb the burst
    run_to(50);
    write_en = 1'b0; read_en = 1'b1; addr = 20'hC0105;
    run_to(60);
    write_en = 1'b1; read_en = 1'b1; addr = 20'h5A3C7;
    run_to(71);
    write_en = 1'b0;
    run_to(89);
    read_en = 1'b0; write_en = 1'b1; addr = 20'h00000;
    run_to(101);
    RST_N = 1'b0; write_en = 1'b0;         // during second write beat
    run_to(102);
    RST_N = 1'b1;
    run_to(142);

    // reset state
    chk("rst_cke", 0, 32'(lg_cke[0]), 32'd0);
    chk("rst_cmd", 0, 32'(lg_cmd[0]), 32'(DESL));
    chk("rst_addr", 0, 32'(lg_addr[0]), 32'd0);
    chk("rst_ba", 0, 32'(lg_ba[0]), 32'd0);
    chk("rst_oe", 0, 32'(lg_oe[0]), 32'd0);
    chk("rst_dqm", 0, 32'(lg_dqm[0]), 32'd0);
    chk("rst_flags", 0, 32'({lg_wack[0], lg_rack[0], lg_wreq[0], lg_rval[0]}), 32'd0);

    // init sequence
    for (int k = 1; k <= 39; k++) begin
      chk("init_cmd", k, 32'(lg_cmd[k]), 32'(init_cmd(k)));
      chk("init_cke", k, 32'(lg_cke[k]), 32'd1);
    end
    chk("pre_a10", 21, 32'(lg_addr[21][10]), 32'd1);
    chk("mrs_addr", 37, 32'(lg_addr[37]), 32'h022);

    // first write
    chk("w1_act", 40, 32'(lg_cmd[40]), 32'(ACT));
    chk("w1_act_ba", 40, 32'(lg_ba[40]), 32'd3);
    chk("w1_act_row", 40, 32'(lg_addr[40]), 32'h001);
    chk("w1_wr", 42, 32'(lg_cmd[42]), 32'(WR));
    chk("w1_wr_col", 42, 32'(lg_addr[42]), 32'h405);
    chk("w1_wr_ba", 42, 32'(lg_ba[42]), 32'd3);
    for (int k = 40; k <= 50; k++) begin
      chk("w1_oe", k, 32'(lg_oe[k]), 32'(k >= 42 && k <= 45));
      chk("w1_req", k, 32'(lg_wreq[k]), 32'(k >= 42 && k <= 45));
    end
    for (int i = 0; i < 4; i++) chk("w1_dq", 42 + i, 32'(lg_dqo[42 + i]), 32'(i + 1));

    // first read
    chk("r1_act", 51, 32'(lg_cmd[51]), 32'(ACT));
    chk("r1_act_row", 51, 32'(lg_addr[51]), 32'h001);
    chk("r1_rd", 53, 32'(lg_cmd[53]), 32'(RD));
    chk("r1_rd_col", 53, 32'(lg_addr[53]), 32'h405);
    for (int k = 51; k <= 61; k++) begin
      chk("r1_valid", k, 32'(lg_rval[k]), 32'(k >= 56 && k <= 59));
      chk("r1_oe", k, 32'(lg_oe[k]), 32'd0);
    end
    for (int i = 0; i < 4; i++) chk("r1_data", 56 + i, 32'(lg_rdd[56 + i]), 32'(i + 1));

    // simultaneous write+read with refresh falling due mid-write
    chk("w2_act", 61, 32'(lg_cmd[61]), 32'(ACT));
    chk("w2_act_ba", 61, 32'(lg_ba[61]), 32'd1);
    chk("w2_act_row", 61, 32'(lg_addr[61]), 32'h1A3);
    chk("w2_wr", 63, 32'(lg_cmd[63]), 32'(WR));
    chk("w2_wr_col", 63, 32'(lg_addr[63]), 32'h4C7);
    for (int i = 0; i < 4; i++) chk("w2_dq", 63 + i, 32'(lg_dqo[63 + i]), 32'(i + 5));
    for (int k = 64; k <= 71; k++) chk("no_ref_mid", k, 32'(lg_cmd[k] == REF), 32'd0);
    chk("ref_after_w", 72, 32'(lg_cmd[72]), 32'(REF));
    chk("r2_act", 80, 32'(lg_cmd[80]), 32'(ACT));
    chk("r2_rd", 82, 32'(lg_cmd[82]), 32'(RD));
    chk("r2_rd_col", 82, 32'(lg_addr[82]), 32'h4C7);
    chk("r2_valid_pre", 84, 32'(lg_rval[84]), 32'd0);
    chk("r2_valid_post", 89, 32'(lg_rval[89]), 32'd0);
    for (int i = 0; i < 4; i++) chk("r2_data", 85 + i, 32'(lg_rdd[85 + i]), 32'(i + 5));

    // ack pulses across the whole run before the reset test
    for (int k = 1; k <= 101; k++) begin
      chk("wack", k, 32'(lg_wack[k]), 32'(k == 50 || k == 71));
      chk("rack", k, 32'(lg_rack[k]), 32'(k == 60 || k == 89));
      chk("dqm", k, 32'(lg_dqm[k]), 32'd0);
    end

    // refresh pending beats a waiting write, then reset mid-burst
    chk("ref_first", 90, 32'(lg_cmd[90]), 32'(REF));
    chk("w3_act", 98, 32'(lg_cmd[98]), 32'(ACT));
    chk("w3_wr", 100, 32'(lg_cmd[100]), 32'(WR));
    chk("w3_beat2_oe", 101, 32'(lg_oe[101]), 32'd1);
    chk("rst_mid_oe", 102, 32'(lg_oe[102]), 32'd0);
    chk("rst_mid_cke", 102, 32'(lg_cke[102]), 32'd0);
    chk("rst_mid_cmd", 102, 32'(lg_cmd[102]), 32'(DESL));
    for (int k = 1; k <= 39; k++) begin
      chk("reinit_cmd", 102 + k, 32'(lg_cmd[102 + k]), 32'(init_cmd(k)));
      chk("reinit_cke", 102 + k, 32'(lg_cke[102 + k]), 32'd1);
    end
    for (int k = 102; k <= 142; k++) chk("no_wack_rst", k, 32'(lg_wack[k]), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
